fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 32-bit pipelined RISC-V core. It owns the PC and drives the synchronous-read instruction memory, whose data returns one cycle after the address is sampled. It buffers the returning instruction so that decode stalls lose nothing, and drops wrong-path fetches on a taken-branch redirect. Outputs feed the decode stage (register file, immediate generator, hazard unit) directly.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on if_id_instr when the slot is a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode stall from the hazard unit; hold IF/ID and PC.
- redirect  in  1  taken branch (PCSrc); flush the front end.
- redirect_pc  in  32  branch target; bits [1:0] ignored and treated as 00.
- imem_addr  out  32  byte address to the instruction memory; equals fetch_pc.
- imem_rdata  in  32  instruction at the address sampled on the previous edge.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_instr  out  32  instruction to decode.

## Operation
- State: fetch_pc; resp_valid/resp_pc (imem_rdata this cycle holds an issued fetch at resp_pc); skid_valid/skid_pc/skid_instr (one-entry buffer); IF/ID output registers.
- Issue: issue = ~stall & ~redirect. On issue: fetch_pc <= fetch_pc + 4, modulo 2^32. Also resp_pc <= fetch_pc and resp_valid <= issue on every edge. Non-issued fetches return data that is discarded.
- Priority per edge: reset > redirect > stall > normal.
- Redirect: fetch_pc <= {redirect_pc[31:2],2'b00}; resp_valid <= 0; skid_valid <= 0; if_id_valid <= 0, if_id_instr <= NOP_INSTR, if_id_pc <= 0. This overrides stall.
- Stall (no redirect): IF/ID registers hold. If resp_valid, skid <= {resp_pc, imem_rdata} and skid_valid <= 1. fetch_pc holds.
- Normal (no stall, no redirect): IF/ID source is skid if skid_valid (then skid_valid <= 0), else resp if resp_valid, else bubble (valid 0, instr NOP_INSTR, pc 0).
- Invariant: skid_valid & resp_valid never both 1. With this invariant, one skid entry makes stall release bubble-free.
- Stall asserted while skid_valid is already set: skid holds unchanged.

## Timing
- Reset values: imem_addr = RESET_PC, if_id_valid = 0, if_id_pc = 0, if_id_instr = NOP_INSTR, resp_valid = 0, skid_valid = 0.
- After reset deasserts at edge E0:
  - RESET_PC is sampled at E1.
  - resp is valid in the following cycle.
  - if_id_valid = 1 with if_id_pc = RESET_PC after E2.
  - Then one instruction per cycle.
- Fetch-to-IF/ID latency is 2 edges. Redirect-to-first-valid-target is 3 edges: fetch_pc updates at the redirect edge, the target is sampled at the next edge, and it is loaded into IF/ID one edge later.
- Stall of N cycles: IF/ID is frozen for N edges. The instruction following the stalled one appears on the first edge with stall = 0, then the stream continues with no bubble and no duplicate.
- Reset mid-stall or mid-redirect: all state returns to reset values at that edge.
- Reset takes effect at the edge regardless of stall or redirect.

## Test plan
- Reset, then run 6 cycles with memory preloaded at 0x00–0x14 → if_id_pc sequence 0,4,8,12,16,20 on consecutive cycles starting 2 edges after reset release. Each if_id_instr matches memory.
- Stall for 1 cycle while if_id_pc = 8 → if_id_pc holds 8 for one extra cycle, then 12, 16 with no gap and no repeat. skid_valid pulses for exactly one cycle.
- Stall for 3 cycles while if_id_pc = 4 → imem_addr is frozen and if_id holds 4. After release, the sequence continues 8, 12 back-to-back.
- Redirect to 0x40 while if_id_pc = 12 → if_id_valid = 0 for 2 cycles with if_id_instr = 0x00000013, then if_id_pc = 0x40, 0x44. The wrong-path fetches at 16 and 20 never become valid.
- Redirect and stall asserted together with skid full → skid is cleared and the target 0x20 is fetched. A redirect_pc of 0x23 yields if_id_pc = 0x20.
- Reset asserted during a 2-cycle stall → next cycle has if_id_valid = 0 and imem_addr = RESET_PC. Normal fetch restarts 2 edges after release.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register for the 32-bit RISC-V core.
//
// Owns the PC and drives a synchronous-read instruction memory whose data
// returns one cycle after the address is sampled. One-entry skid buffer keeps
// decode stalls lossless. Taken-branch redirects drop wrong-path fetches.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   reset        in   synchronous active-high reset
//   stall        in   decode stall: hold IF/ID and PC
//   redirect     in   taken branch: flush the front end
//   redirect_pc  in   branch target, bits [1:0] treated as 00
//   imem_addr    out  byte address to instruction memory (fetch_pc)
//   imem_rdata   in   instruction at the address sampled on the previous edge
//   if_id_valid  out  IF/ID slot holds a real instruction
//   if_id_pc     out  PC of if_id_instr
//   if_id_instr  out  instruction to decode (NOP_INSTR when bubble)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);
    logic [31:0] fetch_pc;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        issue;
    logic [31:0] target;
    logic        nxt_valid;
    logic [31:0] nxt_pc;
    logic [31:0] nxt_instr;

    assign issue     = ~stall & ~redirect;
    assign target    = redirect_pc & ~32'h3;
    assign imem_addr = fetch_pc;

    // The skid entry is always older than the in-flight response, so it goes first.
    always_comb begin
        nxt_valid = skid_valid | resp_valid;
        nxt_pc    = skid_valid ? skid_pc : resp_valid ? resp_pc : 32'h0;
        nxt_instr = skid_valid ? skid_instr : resp_valid ? imem_rdata : NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_valid  <= 1'b0;
            resp_pc     <= 32'h0;
            skid_valid  <= 1'b0;
            skid_pc     <= 32'h0;
            skid_instr  <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_instr <= NOP_INSTR;
        end else begin
            // A fetch that was not issued still returns data next cycle; it is tagged invalid.
            resp_pc    <= fetch_pc;
            resp_valid <= issue;
            if (redirect) begin
                fetch_pc    <= target;
                skid_valid  <= 1'b0;
                if_id_valid <= 1'b0;
                if_id_pc    <= 32'h0;
                if_id_instr <= NOP_INSTR;
            end else if (stall) begin
                // Capture the response that would otherwise be lost; a held skid stays put.
                if (resp_valid && !skid_valid) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= resp_pc;
                    skid_instr <= imem_rdata;
                end
            end else begin
                fetch_pc    <= fetch_pc + 32'd4;
                skid_valid  <= 1'b0;
                if_id_valid <= nxt_valid;
                if_id_pc    <= nxt_pc;
                if_id_instr <= nxt_instr;
            end
        end
    end
endmodule
